// File: rtl/svm_pkg.sv
// svm_pkg: shared constants and types for the SVM dot-product datapath.
//   DATA_WIDTH     IEEE-754 single operand width
//   VEC_LEN_MAX    max elements per vector (power of two)
//   NUM_SV         support-vector rows held in SV memory
//   IDX_WIDTH      element index width, LEN_WIDTH element count width
//   SV_ADDR_WIDTH  SV memory address width ({row, element})
package svm_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int VEC_LEN_MAX   = 64;
  localparam int NUM_SV        = 16;
  localparam int IDX_WIDTH     = $clog2(VEC_LEN_MAX);
  localparam int LEN_WIDTH     = IDX_WIDTH + 1;
  localparam int SV_IDX_WIDTH  = $clog2(NUM_SV);
  localparam int SV_ADDR_WIDTH = SV_IDX_WIDTH + IDX_WIDTH;

  localparam int EXP_LSB = 23;
  localparam int EXP_MSB = 30;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} feeder_state_t;

  // Requested element count limited to what one row can hold.
  function automatic logic [LEN_WIDTH-1:0] clamp_len(input logic [LEN_WIDTH-1:0] n);
    return (n > LEN_WIDTH'(VEC_LEN_MAX)) ? LEN_WIDTH'(VEC_LEN_MAX) : n;
  endfunction

  // Zero or denormal: exponent field all zeros.
  function automatic logic exp_is_zero(input logic [DATA_WIDTH-1:0] d);
    return d[EXP_MSB:EXP_LSB] == '0;
  endfunction

endpackage

// File: rtl/fp_mult_operand_feeder_if.sv
// fp_mult_operand_feeder_if: control, memory-read and fp_mult operand signals
// of the operand feeder.
//   master modport: the feeder (drives reads, operands, status)
//   slave  modport: the environment (controller, memories, fp_mult)
//   skip_cnt exists only when FP_ZERO_SKIP_EN is defined.
interface fp_mult_operand_feeder_if;
  import svm_pkg::*;

  logic                     start;
  logic                     abort;
  logic [SV_IDX_WIDTH-1:0]  sv_idx;
  logic [LEN_WIDTH-1:0]     vec_len;
  logic                     busy;
  logic                     done;
  logic                     sv_rd_en;
  logic [SV_ADDR_WIDTH-1:0] sv_rd_addr;
  logic [DATA_WIDTH-1:0]    sv_rd_data;
  logic                     x_rd_en;
  logic [IDX_WIDTH-1:0]     x_rd_addr;
  logic [DATA_WIDTH-1:0]    x_rd_data;
  logic [DATA_WIDTH-1:0]    data_1;
  logic [DATA_WIDTH-1:0]    data_2;
  logic                     mult_en;
  logic                     last_o;
`ifdef FP_ZERO_SKIP_EN
  logic [IDX_WIDTH:0]       skip_cnt;
`endif

  modport master (
    input  start, abort, sv_idx, vec_len, sv_rd_data, x_rd_data,
`ifdef FP_ZERO_SKIP_EN
    output skip_cnt,
`endif
    output busy, done, sv_rd_en, sv_rd_addr, x_rd_en, x_rd_addr,
    output data_1, data_2, mult_en, last_o
  );

  modport slave (
    output start, abort, sv_idx, vec_len, sv_rd_data, x_rd_data,
`ifdef FP_ZERO_SKIP_EN
    input  skip_cnt,
`endif
    input  busy, done, sv_rd_en, sv_rd_addr, x_rd_en, x_rd_addr,
    input  data_1, data_2, mult_en, last_o
  );

endinterface

// File: rtl/fp_feed_addr_gen.sv
// fp_feed_addr_gen: element counter and read address generation.
//   clk, rst_n   clock, synchronous active-low reset
//   active       high while the feeder is in FETCH
//   sv_idx_q     latched SV row, len_q latched (clamped) element count
//   issue        a read is issued this cycle
//   issue_last   the read issued this cycle is element len_q-1
//   sv_rd_addr   {sv_idx_q, elem_idx}, x_rd_addr elem_idx
module fp_feed_addr_gen import svm_pkg::*; (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     active,
  input  logic [SV_IDX_WIDTH-1:0]  sv_idx_q,
  input  logic [LEN_WIDTH-1:0]     len_q,
  output logic                     issue,
  output logic                     issue_last,
  output logic [SV_ADDR_WIDTH-1:0] sv_rd_addr,
  output logic [IDX_WIDTH-1:0]     x_rd_addr
);

  logic [IDX_WIDTH-1:0] elem_idx;

  assign issue      = active;
  assign issue_last = active && ({1'b0, elem_idx} == len_q - LEN_WIDTH'(1));

  // The counter returns to 0 after the last issue, so it never wraps inside
  // a transfer even when len_q equals VEC_LEN_MAX.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n)                    elem_idx <= '0;
    else if (issue && !issue_last) elem_idx <= elem_idx + IDX_WIDTH'(1);
    else                           elem_idx <= '0;
  end

  // Row-major layout with a power-of-two row stride: concatenation, no adder.
  assign sv_rd_addr = {sv_idx_q, elem_idx};
  assign x_rd_addr  = elem_idx;

endmodule

// File: rtl/fp_mult_operand_feeder.sv
// fp_mult_operand_feeder: reads one SV row and the X vector element by element
// and presents matched operand pairs to fp_mult with a one-cycle mult_en each.
//   clk, rst_n  clock, synchronous active-low reset
//   bus         fp_mult_operand_feeder_if.master: start/abort/sv_idx/vec_len
//               in; busy/done status; SV and X read ports; data_1/data_2/
//               mult_en/last_o to fp_mult.
// Optional: define FP_ZERO_SKIP_EN to suppress mult_en for elements with a
// zero/denormal operand (operands forced to 0) and count them in skip_cnt.
module fp_mult_operand_feeder import svm_pkg::*; (
  input  logic                      clk,
  input  logic                      rst_n,
  fp_mult_operand_feeder_if.master  bus
);

  feeder_state_t            state_q, state_d;
  logic [SV_IDX_WIDTH-1:0]  sv_idx_q;
  logic [LEN_WIDTH-1:0]     len_q;
  logic                     issue, issue_last;
  logic                     running, fetching, start_ok, kill;
  logic                     rd_vld_q, rd_last_q;
  logic                     skip;
  logic                     mult_en_q, last_q;
  logic [DATA_WIDTH-1:0]    data_1_q, data_2_q;

  assign running  = (state_q == FETCH) || (state_q == DRAIN);
  assign fetching = (state_q == FETCH);
  assign start_ok = (state_q == IDLE) && bus.start;
  assign kill     = running && bus.abort;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d is assigned before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (bus.start) state_d = (bus.vec_len == '0) ? DONE : FETCH;
      FETCH: if (bus.abort) state_d = IDLE;
             else if (issue_last) state_d = DRAIN;
      DRAIN: state_d = bus.abort ? IDLE : DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sv_idx_q <= '0;
      len_q    <= '0;
    end else if (start_ok && (bus.vec_len != '0)) begin
      sv_idx_q <= bus.sv_idx;
      len_q    <= clamp_len(bus.vec_len);
    end
  end

  fp_feed_addr_gen u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .active     (fetching),
    .sv_idx_q   (sv_idx_q),
    .len_q      (len_q),
    .issue      (issue),
    .issue_last (issue_last),
    .sv_rd_addr (bus.sv_rd_addr),
    .x_rd_addr  (bus.x_rd_addr)
  );

  // Stage 1 tracks reads in flight (data returns next cycle); abort drops
  // them so nothing issued before the abort reaches fp_mult.
  always_ff @(posedge clk) begin
    if (!rst_n || kill) begin
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      rd_vld_q  <= issue;
      rd_last_q <= issue_last;
    end
  end

`ifdef FP_ZERO_SKIP_EN
  logic [IDX_WIDTH:0] skip_cnt_q;

  assign skip = rd_vld_q && (exp_is_zero(bus.sv_rd_data) || exp_is_zero(bus.x_rd_data));

  always_ff @(posedge clk) begin
    if (!rst_n)             skip_cnt_q <= '0;
    else if (start_ok)      skip_cnt_q <= '0;
    else if (skip && !kill) skip_cnt_q <= skip_cnt_q + (IDX_WIDTH+1)'(1);
  end

  assign bus.skip_cnt = skip_cnt_q;
`else
  assign skip = 1'b0;
`endif

  // Stage 2: operand register. last_q follows the read pipeline alone so the
  // final element is marked even when its multiply is skipped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mult_en_q <= 1'b0;
      last_q    <= 1'b0;
      data_1_q  <= '0;
      data_2_q  <= '0;
    end else if (kill) begin
      mult_en_q <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      mult_en_q <= rd_vld_q && !skip;
      last_q    <= rd_last_q;
      if (rd_vld_q) begin
        data_1_q <= skip ? '0 : bus.sv_rd_data;
        data_2_q <= skip ? '0 : bus.x_rd_data;
      end
    end
  end

  assign bus.busy     = running;
  assign bus.done     = (state_q == DONE);
  assign bus.sv_rd_en = issue;
  assign bus.x_rd_en  = issue;
  assign bus.data_1   = data_1_q;
  assign bus.data_2   = data_2_q;
  assign bus.mult_en  = mult_en_q;
  assign bus.last_o   = last_q;

endmodule

// File: tb/tb_fp_mult_operand_feeder.sv
// Scoreboard bench for fp_mult_operand_feeder: expected reads and operand
// pairs are queued when a start is driven and compared as the DUT emits them.
module tb_fp_mult_operand_feeder;
  import svm_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_mult_operand_feeder_if bus ();

  fp_mult_operand_feeder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DATA_WIDTH-1:0] sv_mem [NUM_SV*VEC_LEN_MAX];
  logic [DATA_WIDTH-1:0] x_mem  [VEC_LEN_MAX];

  // Memories with one cycle read latency.
  always @(posedge clk) begin
    if (bus.sv_rd_en) bus.sv_rd_data <= sv_mem[bus.sv_rd_addr];
    if (bus.x_rd_en)  bus.x_rd_data  <= x_mem[bus.x_rd_addr];
  end

  typedef struct {
    int sv_addr;
    int x_addr;
    int cyc;
  } rd_exp_t;

  typedef struct {
    logic [DATA_WIDTH-1:0] d1;
    logic [DATA_WIDTH-1:0] d2;
    logic                  last;
    logic                  en;
    int                    cyc;
  } op_exp_t;

  rd_exp_t rd_q[$];
  op_exp_t op_q[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int exp_done_cyc = -1;
  int done_cnt = 0;
  int exp_skip = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit model_skip(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
`ifdef FP_ZERO_SKIP_EN
    return (a[30:23] == 8'h00) || (b[30:23] == 8'h00);
`else
    return (a === b) && 1'b0;
`endif
  endfunction

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    rd_exp_t r;
    op_exp_t o;
    if (rst_n) begin
      if (bus.sv_rd_en || bus.x_rd_en) begin
        if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
        else begin
          r = rd_q.pop_front();
          check("sv_rd_en", bus.sv_rd_en, 1);
          check("x_rd_en", bus.x_rd_en, 1);
          check("sv_rd_addr", bus.sv_rd_addr, r.sv_addr);
          check("x_rd_addr", bus.x_rd_addr, r.x_addr);
          check("rd_cycle", cyc, r.cyc);
        end
      end
      if (bus.mult_en || bus.last_o) begin
        if (op_q.size() == 0) check("op_unexpected", 1, 0);
        else begin
          o = op_q.pop_front();
          check("mult_en", bus.mult_en, o.en);
          check("data_1", bus.data_1, o.d1);
          check("data_2", bus.data_2, o.d2);
          check("last_o", bus.last_o, o.last);
          check("op_cycle", cyc, o.cyc);
        end
      end
      if (bus.done) begin
        check("done_cycle", cyc, exp_done_cyc);
        done_cnt++;
      end
    end
  end

  // Drives a one-cycle start and queues the expected reads/operands.
  // n_rd/n_op limit how many are expected (shortened for an abort).
  task automatic start_xfer(input int sv, input int vl, input int n_rd, input int n_op,
                            input bit exp_done, input bit with_abort, output int s);
    int len;
    logic [DATA_WIDTH-1:0] d1, d2;
    bit sk, last;
    @(negedge clk); #1;
    s   = cyc;
    len = (vl > VEC_LEN_MAX) ? VEC_LEN_MAX : vl;
    bus.start   = 1'b1;
    bus.abort   = with_abort;
    bus.sv_idx  = sv[SV_IDX_WIDTH-1:0];
    bus.vec_len = vl[LEN_WIDTH-1:0];
    exp_skip    = 0;
    for (int i = 0; i < n_rd; i++)
      rd_q.push_back('{sv_addr: sv*VEC_LEN_MAX + i, x_addr: i, cyc: s + 1 + i});
    for (int i = 0; i < n_op; i++) begin
      d1   = sv_mem[sv*VEC_LEN_MAX + i];
      d2   = x_mem[i];
      last = (i == len - 1);
      sk   = model_skip(d1, d2);
      if (sk) exp_skip++;
      if (!sk || last)
        op_q.push_back('{d1: sk ? '0 : d1, d2: sk ? '0 : d2, last: last, en: !sk, cyc: s + 3 + i});
    end
    exp_done_cyc = !exp_done ? -1 : ((len == 0) ? s + 1 : s + len + 2);
    @(negedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic settle(input int n, input string tag);
    repeat (n) @(negedge clk);
    #1;
    check({tag, "_rd_drained"}, rd_q.size(), 0);
    check({tag, "_op_drained"}, op_q.size(), 0);
    check({tag, "_idle"}, bus.busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_sv_rd_en"}, bus.sv_rd_en, 0);
    check({tag, "_x_rd_en"}, bus.x_rd_en, 0);
    check({tag, "_sv_rd_addr"}, bus.sv_rd_addr, 0);
    check({tag, "_x_rd_addr"}, bus.x_rd_addr, 0);
    check({tag, "_data_1"}, bus.data_1, 0);
    check({tag, "_data_2"}, bus.data_2, 0);
    check({tag, "_mult_en"}, bus.mult_en, 0);
    check({tag, "_last_o"}, bus.last_o, 0);
  endtask

  initial begin
    int s, d0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.sv_idx = '0;
    bus.vec_len = '0;
    bus.sv_rd_data = '0;
    bus.x_rd_data = '0;
    for (int i = 0; i < NUM_SV*VEC_LEN_MAX; i++) sv_mem[i] = 32'h4000_0000 + i;
    for (int i = 0; i < VEC_LEN_MAX; i++)        x_mem[i]  = 32'h3F00_0000 + (i << 4);
    for (int i = 0; i < 4; i++) begin
      sv_mem[3*VEC_LEN_MAX + i] = 32'h3F80_0000;
      x_mem[i]                  = 32'h4000_0000;
    end

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Basic transfer: row 3, four elements.
    d0 = done_cnt;
    start_xfer(3, 4, 4, 4, 1, 0, s);
    check("basic_busy", bus.busy, 1);
    settle(8, "basic");
    check("basic_done_cnt", done_cnt - d0, 1);

    // Zero length: straight to DONE, no reads.
    d0 = done_cnt;
    start_xfer(5, 0, 0, 0, 1, 0, s);
    check("zero_busy", bus.busy, 0);
    settle(4, "zero");
    check("zero_done_cnt", done_cnt - d0, 1);

    // Clamp: 100 requested, 64 performed, index never wraps.
    d0 = done_cnt;
    start_xfer(1, 100, 64, 64, 1, 0, s);
    settle(70, "clamp");
    check("clamp_done_cnt", done_cnt - d0, 1);

    // Abort on the 3rd FETCH cycle: 3 reads, only element 0 reaches fp_mult.
    d0 = done_cnt;
    start_xfer(7, 8, 3, 1, 0, 0, s);
    repeat (2) @(negedge clk);
    #1;
    bus.abort = 1'b1;
    @(negedge clk); #1;
    bus.abort = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_rd_drained", rd_q.size(), 0);
    // Restart right away, with abort asserted alongside start (start wins).
    start_xfer(4, 5, 5, 5, 1, 1, s);
    settle(10, "restart");
    check("abort_restart_done_cnt", done_cnt - d0, 1);

    // start pulsed in FETCH and in DONE is ignored.
    d0 = done_cnt;
    start_xfer(5, 8, 8, 8, 1, 0, s);
    repeat (3) @(negedge clk);
    #1;
    bus.start = 1'b1; bus.sv_idx = 4'd9; bus.vec_len = 7'd2;
    @(negedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("ignore_in_done", bus.done, 1);
    bus.start = 1'b1;
    @(negedge clk); #1;
    bus.start = 1'b0;
    settle(6, "ignore");
    check("ignore_done_cnt", done_cnt - d0, 1);

    // Reset mid-FETCH: everything clears, in-flight reads vanish.
    d0 = done_cnt;
    start_xfer(6, 10, 10, 10, 1, 0, s);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b0;
    rd_q.delete();
    op_q.delete();
    @(negedge clk); #1;
    check_all_zero("midreset");
    rst_n = 1'b1;
    settle(6, "midreset");
    check("midreset_done_cnt", done_cnt - d0, 0);

    // Zero SV operand at element 2: skipped when the feature is built in,
    // passed through unchanged otherwise.
    sv_mem[2*VEC_LEN_MAX + 2] = 32'h0000_0000;
    d0 = done_cnt;
    start_xfer(2, 4, 4, 4, 1, 0, s);
    settle(8, "zero_elem");
    check("zero_elem_done_cnt", done_cnt - d0, 1);
`ifdef FP_ZERO_SKIP_EN
    check("skip_cnt", bus.skip_cnt, exp_skip);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_mult_operand_feeder.md
Name: fp_mult_operand_feeder

Overview:
- Initiator side of the multiplier/accumulator datapath for SVM dot products.
- On start, reads one support vector (SV) row from SV memory and the feature vector (X) from X memory, element by element.
- Drives matched operand pairs onto fp_mult data_1/data_2 with a one-cycle mult_en strobe per element; the downstream accumulator consumes these strobes.
- Signals the final element (last_o) and completion (done).

Parameters:
- DATA_WIDTH, 32, IEEE-754 single operand width
- VEC_LEN_MAX, 64, max elements per vector; power of two
- NUM_SV, 16, SV rows stored in SV memory
- IDX_WIDTH, 6, log2(VEC_LEN_MAX), element index width
- SV_ADDR_WIDTH, 10, log2(NUM_SV*VEC_LEN_MAX)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle request; accepted only in IDLE
- abort  in  1  synchronous cancel of a running transfer
- sv_idx  in  log2(NUM_SV)  SV row to process; latched on start
- vec_len  in  IDX_WIDTH+1  element count; latched on start
- busy  out  1  high in FETCH/DRAIN
- done  out  1  one-cycle pulse at normal completion
- sv_rd_en  out  1  SV memory read strobe
- sv_rd_addr  out  SV_ADDR_WIDTH  sv_idx*VEC_LEN_MAX + elem_idx
- sv_rd_data  in  DATA_WIDTH  SV read data, valid 1 cycle after sv_rd_en
- x_rd_en  out  1  X memory read strobe; same timing as sv_rd_en
- x_rd_addr  out  IDX_WIDTH  elem_idx
- x_rd_data  in  DATA_WIDTH  X read data, valid 1 cycle after x_rd_en
- data_1  out  DATA_WIDTH  registered SV operand to fp_mult
- data_2  out  DATA_WIDTH  registered X operand to fp_mult
- mult_en  out  1  operand pair valid; drives fp_mult mult_en
- last_o  out  1  marks the final element's operand cycle

Behaviour:
- Reset (rst_n low at clk edge):
  - state to IDLE.
  - All outputs 0: busy, done, rd_en, addresses, data_1, data_2, mult_en, last_o.
  - elem_idx to 0.
  - Reset mid-transfer discards in-flight reads; no mult_en follows.
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - start=1 with vec_len!=0: latch sv_idx and len = min(vec_len, VEC_LEN_MAX); go to FETCH.
  - start=1 with vec_len==0: go to DONE directly; no reads, no mult_en.
- FETCH:
  - Each cycle asserts sv_rd_en and x_rd_en with elem_idx, then increments elem_idx.
  - After issuing elem_idx==len-1, go to DRAIN.
  - Exactly len consecutive read cycles; no gaps.
- DRAIN: one cycle for the final read return, then go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Operand path (fixed read latency 1):
  - data_1/data_2 registered from read data the cycle after the read.
  - mult_en = read strobe delayed 2 cycles (read cycle, then operand register).
  - First mult_en occurs 3 cycles after the start cycle.
- last_o:
  - Asserted with the mult_en of element len-1.
  - Never asserted without mult_en, except under the optional feature below.
- done timing: done rises the cycle after the last read-data capture, i.e. coincident with the last mult_en/last_o.
- start while busy or in DONE: ignored; latched values unchanged.
- abort:
  - Sampled in FETCH/DRAIN: next state IDLE.
  - Pipeline valid bits cleared, so no further mult_en or last_o; done not pulsed.
  - abort in IDLE: no effect.
  - abort and start in the same IDLE cycle: start wins.
- Address arithmetic: sv_rd_addr = {sv_idx_q, elem_idx}, a concatenation with no adder. elem_idx never wraps within a transfer.
- data_1/data_2 hold their last value when mult_en=0.

Optional Feature:
- Macro: FP_ZERO_SKIP_EN.
- Defined:
  - An element where either operand has exponent field 8'h00 (zero/denormal) is flagged skip.
  - For a skipped element: mult_en stays 0, and data_1/data_2 are driven to 32'h0.
  - last_o still pulses on the final element's operand cycle even if that element is skipped.
  - Output skip_cnt [IDX_WIDTH:0] counts skipped elements; cleared on start.
- Undefined:
  - Every element produces mult_en; no skip_cnt port.
  - Zero operands pass unchanged to fp_mult.

Decomposition:
- Shared package svm_pkg: DATA_WIDTH, VEC_LEN_MAX, NUM_SV, derived widths, and the feeder_state_t enum {IDLE, FETCH, DRAIN, DONE}.
- The existing param.sv constants migrate into svm_pkg.
- One natural sub-module: fp_feed_addr_gen. It holds the elem_idx counter, the len compare, and address concatenation, and outputs issue and issue_last.

Test Plan:
- Basic transfer: sv_idx=3, vec_len=4, SV mem[192..195]=3F800000, X mem[0..3]=40000000.
  - Reads at addr 192..195 and 0..3 on 4 consecutive cycles.
  - mult_en high 4 cycles starting 3 cycles after start; data_1=3F800000, data_2=40000000.
  - last_o on the 4th; done coincident with the 4th.
- Zero length: vec_len=0 → no rd_en, no mult_en, done 1 cycle after start; busy stays 0.
- Clamp and boundary: vec_len=7'd100 with VEC_LEN_MAX=64 → exactly 64 reads, x_rd_addr 0..63, last_o on element 63, no wrap to 0.
- Abort and restart:
  - vec_len=8, abort on the 3rd FETCH cycle → at most 3 reads issued, no mult_en after the abort edge, no done, back in IDLE.
  - A new start 1 cycle later runs cleanly.
- Reset and start handling:
  - rst_n low mid-FETCH → all outputs 0 the next cycle.
  - start pulsed during busy → ignored; transfer count unchanged.
- FP_ZERO_SKIP_EN: vec_len=4, SV element 2 = 00000000 → mult_en on elements 0, 1, 3 only; skip_cnt=1; last_o on element 3.
